regfile_wb_arbiter: RTL and testbench

Write-port controller for the 32x32 register file. Two writeback sources share the file's single write port: source A (ALU result) and source B (load return). The block arbitrates them round-robin over valid/ready handshakes and registers the winning write onto the file's `regwrite`/`writereg`/`data` inputs. Optionally, it sequences a zero-fill of every register after reset before accepting traffic.

---
 rtl/regfile_wb_arbiter_pkg.sv | 31 +++
 rtl/regfile_wb_arbiter_rr_arb2.sv | 42 ++++
 rtl/regfile_wb_arbiter.sv | 167 ++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the register-file write-port controller.
//   RF_NUM_REGS / RF_ADDR_W / RF_DATA_W : default geometry of the register file
//   rf_wreq_t                           : one write request {addr, data}
//   rf_src_e                            : writeback source, used as arbiter priority
//   rf_arb_state_e                      : controller state (INIT only used when the
//                                         RF_CLEAR_SEQ_EN clear sequence is built)
// -----------------------------------------------------------------------------
package rf_pkg;

    localparam int RF_NUM_REGS = 32;
    localparam int RF_ADDR_W   = 5;
    localparam int RF_DATA_W   = 32;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } rf_wreq_t;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } rf_src_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } rf_arb_state_e;

endpackage : rf_pkg

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin arbiter. Grants are combinational from the request
// vector and the priority register; the priority flips to the other requester
// after every grant and holds on idle cycles.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset (priority returns to requester 0)
//   req  : request vector, bit 0 = source A, bit 1 = source B
//   gnt  : one-hot grant (or zero when nothing is requested)
// -----------------------------------------------------------------------------
module rr_arb2
    import rf_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    rf_src_e prio_r;

    // Grant the sole requester, or the prioritised one under contention.
    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req[0] && (!req[1] || (prio_r == SRC_A));
        gnt[1] = req[1] && (!req[0] || (prio_r == SRC_B));
    end

    // Priority hands over to the other source after each grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_r <= SRC_A;
        end else if (gnt[0]) begin
            prio_r <= SRC_B;
        end else if (gnt[1]) begin
            prio_r <= SRC_A;
        end else begin
            prio_r <= prio_r;
        end
    end

endmodule : rr_arb2

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
// Write-port controller for the register file. Sources A (ALU) and B (load
// return) compete round-robin for the single write port; the winning write is
// registered onto rf_we/rf_waddr/rf_wdata for exactly one cycle.
// Writes to register 0 or to addresses >= NUM_REGS are accepted but dropped.
//
// Build option: define RF_CLEAR_SEQ_EN to zero-fill every register after reset
// (INIT state) before any request is accepted.
//
// Ports:
//   clk                          : clock, rising edge
//   clr                          : asynchronous active-high reset
//   a_valid/a_addr/a_data/a_ready: source A handshake (ready is combinational)
//   b_valid/b_addr/b_data/b_ready: source B handshake (ready is combinational)
//   rf_we/rf_waddr/rf_wdata      : registered write port to the register file
//   init_done                    : high while in RUN and accepting requests
// -----------------------------------------------------------------------------
module regfile_wb_arbiter
    import rf_pkg::*;
#(
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int DATA_W   = RF_DATA_W
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              init_done
);

    // One extra bit so NUM_REGS == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

    // Register 0 is hard-wired zero; out-of-range addresses have no storage.
    function automatic logic addr_writable(input logic [ADDR_W-1:0] addr);
        return (addr != {ADDR_W{1'b0}}) && ({1'b0, addr} < NUM_REGS_W);
    endfunction

    logic              run_s;
    logic              in_init_s;
    logic [ADDR_W-1:0] init_addr_s;
    logic [1:0]        req_s;
    logic [1:0]        gnt_s;
    logic              we_nxt_s;
    logic [ADDR_W-1:0] waddr_nxt_s;
    logic [DATA_W-1:0] wdata_nxt_s;

`ifdef RF_CLEAR_SEQ_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    rf_arb_state_e     state_r;
    rf_arb_state_e     state_nxt_s;
    logic [ADDR_W-1:0] clr_cnt_r;
    logic [ADDR_W-1:0] clr_cnt_nxt_s;

    // State and clear-counter registers; clearing restarts at register 0 on reset.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r   <= ST_INIT;
            clr_cnt_r <= {ADDR_W{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            clr_cnt_r <= clr_cnt_nxt_s;
        end
    end

    // INIT walks the counter through every register, leaving on the last one.
    always_comb begin
        state_nxt_s   = state_r;
        clr_cnt_nxt_s = clr_cnt_r;
        case (state_r)
            ST_INIT: begin
                if (clr_cnt_r == LAST_ADDR) begin
                    state_nxt_s   = ST_RUN;
                    clr_cnt_nxt_s = {ADDR_W{1'b0}};
                end else begin
                    clr_cnt_nxt_s = clr_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            ST_RUN: begin
                state_nxt_s = ST_RUN;
            end
            default: begin
                state_nxt_s   = ST_INIT;
                clr_cnt_nxt_s = {ADDR_W{1'b0}};
            end
        endcase
    end

    assign run_s       = (state_r == ST_RUN);
    assign in_init_s   = (state_r == ST_INIT);
    assign init_addr_s = clr_cnt_r;
`else
    assign run_s       = 1'b1;
    assign in_init_s   = 1'b0;
    assign init_addr_s = {ADDR_W{1'b0}};
`endif

    assign init_done = run_s;

    // Requests are held off entirely until the controller is in RUN.
    assign req_s = {b_valid, a_valid} & {2{run_s}};

    rr_arb2 u_arb (
        .clk (clk),
        .rst (clr),
        .req (req_s),
        .gnt (gnt_s)
    );

    assign a_ready = gnt_s[0];
    assign b_ready = gnt_s[1];

    // Select what the write port carries next cycle: clear write, winner, or idle.
    always_comb begin
        we_nxt_s    = 1'b0;
        waddr_nxt_s = {ADDR_W{1'b0}};
        wdata_nxt_s = {DATA_W{1'b0}};
        if (in_init_s) begin
            we_nxt_s    = 1'b1;
            waddr_nxt_s = init_addr_s;
        end else if (gnt_s[0]) begin
            if (addr_writable(a_addr)) begin
                we_nxt_s    = 1'b1;
                waddr_nxt_s = a_addr;
                wdata_nxt_s = a_data;
            end else begin
                we_nxt_s = 1'b0;
            end
        end else if (gnt_s[1]) begin
            if (addr_writable(b_addr)) begin
                we_nxt_s    = 1'b1;
                waddr_nxt_s = b_addr;
                wdata_nxt_s = b_data;
            end else begin
                we_nxt_s = 1'b0;
            end
        end else begin
            we_nxt_s = 1'b0;
        end
    end

    // Output register; a write captured but not yet issued is lost on clr.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rf_we    <= 1'b0;
            rf_waddr <= {ADDR_W{1'b0}};
            rf_wdata <= {DATA_W{1'b0}};
        end else begin
            rf_we    <= we_nxt_s;
            rf_waddr <= waddr_nxt_s;
            rf_wdata <= wdata_nxt_s;
        end
    end

endmodule : regfile_wb_arbiter

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Self-checking bench for regfile_wb_arbiter. Two source queues drive the
// handshakes; a reference priority model predicts readys and pushes the
// expected write-port contents to a scoreboard, popped one cycle later. A small
// register-file model captures writes on the falling edge for read-back checks.
// Works with or without RF_CLEAR_SEQ_EN defined.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } req_t;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        clr;
    logic        a_valid;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        b_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        init_done;

    int n_checks;
    int n_fails;

    req_t  a_q[$];
    req_t  b_q[$];
    exp_t  exp_q[$];
    logic  m_prio;
    logic [31:0] rf_model [32];

    regfile_wb_arbiter #(
        .NUM_REGS (32),
        .ADDR_W   (5),
        .DATA_W   (32)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .a_valid   (a_valid),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: captures on the falling edge inside the write cycle.
    initial begin
        for (int i = 0; i < 32; i++) rf_model[i] = 32'h0;
    end
    always @(negedge clk) begin
        if (rf_we === 1'b1) rf_model[rf_waddr] <= rf_wdata;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock cycle: present queue heads, check readys, score the write port.
    task automatic step();
        exp_t e;
        logic ea, eb;
        a_valid = (a_q.size() > 0);
        a_addr  = a_valid ? a_q[0].addr : 5'd0;
        a_data  = a_valid ? a_q[0].data : 32'h0;
        b_valid = (b_q.size() > 0);
        b_addr  = b_valid ? b_q[0].addr : 5'd0;
        b_data  = b_valid ? b_q[0].data : 32'h0;
        @(negedge clk);
        ea = a_valid && (!b_valid || (m_prio == 1'b0));
        eb = b_valid && (!a_valid || (m_prio == 1'b1));
        check_eq("a_ready", {31'd0, a_ready}, {31'd0, ea});
        check_eq("b_ready", {31'd0, b_ready}, {31'd0, eb});
        e.we = 1'b0; e.addr = 5'd0; e.data = 32'h0;
        if (ea) begin
            if (a_addr != 5'd0) begin e.we = 1'b1; e.addr = a_addr; e.data = a_data; end
            void'(a_q.pop_front());
            m_prio = 1'b1;
        end else if (eb) begin
            if (b_addr != 5'd0) begin e.we = 1'b1; e.addr = b_addr; e.data = b_data; end
            void'(b_q.pop_front());
            m_prio = 1'b0;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_eq("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_eq("rf_we", {31'd0, rf_we}, {31'd0, e.we});
            check_eq("rf_waddr", {27'd0, rf_waddr}, {27'd0, e.addr});
            check_eq("rf_wdata", rf_wdata, e.data);
        end
        check_eq("init_done_run", {31'd0, init_done}, 32'd1);
    endtask

    // Assert clr (outputs must clear at once), release it, then follow any clear sequence.
    task automatic do_reset();
        logic exp_done;
`ifdef RF_CLEAR_SEQ_EN
        exp_done = 1'b0;
`else
        exp_done = 1'b1;
`endif
        clr = 1'b1;
        a_valid = 1'b0; a_addr = 5'd0; a_data = 32'h0;
        b_valid = 1'b0; b_addr = 5'd0; b_data = 32'h0;
        a_q.delete(); b_q.delete(); exp_q.delete();
        m_prio = 1'b0;
        #2;
        check_eq("rst_rf_we", {31'd0, rf_we}, 32'd0);
        check_eq("rst_rf_waddr", {27'd0, rf_waddr}, 32'd0);
        check_eq("rst_rf_wdata", rf_wdata, 32'h0);
        check_eq("rst_init_done", {31'd0, init_done}, {31'd0, exp_done});
        @(posedge clk);
        #1;
        clr = 1'b0;
`ifdef RF_CLEAR_SEQ_EN
        a_valid = 1'b1; a_addr = 5'd9;  a_data = 32'h1111_1111;
        b_valid = 1'b1; b_addr = 5'd10; b_data = 32'h2222_2222;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            check_eq("init_a_ready", {31'd0, a_ready}, 32'd0);
            check_eq("init_b_ready", {31'd0, b_ready}, 32'd0);
            @(posedge clk);
            #1;
            check_eq("init_rf_we", {31'd0, rf_we}, 32'd1);
            check_eq("init_rf_waddr", {27'd0, rf_waddr}, i);
            check_eq("init_rf_wdata", rf_wdata, 32'h0);
            check_eq("init_done_seq", {31'd0, init_done}, (i == 31) ? 32'd1 : 32'd0);
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
`endif
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fails  = 0;
        clr = 1'b1;
        a_valid = 1'b0; a_addr = 5'd0; a_data = 32'h0;
        b_valid = 1'b0; b_addr = 5'd0; b_data = 32'h0;
        m_prio = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Single writer A to r5.
        a_q.push_back('{addr: 5'd5, data: 32'hDEAD_BEEF});
        step();
        step();
        check_eq("rf_r5", rf_model[5], 32'hDEAD_BEEF);

        // B writes register 0: accepted, dropped.
        b_q.push_back('{addr: 5'd0, data: 32'h0000_1234});
        step();
        step();
        check_eq("rf_r0", rf_model[0], 32'h0);

        // Contention: four back-to-back grants A, B, A, B.
        a_q.push_back('{addr: 5'd1, data: 32'hA000_0001});
        a_q.push_back('{addr: 5'd2, data: 32'hA000_0002});
        b_q.push_back('{addr: 5'd3, data: 32'hB000_0003});
        b_q.push_back('{addr: 5'd4, data: 32'hB000_0004});
        for (int i = 0; i < 4; i++) step();
        step();
        check_eq("rf_r1", rf_model[1], 32'hA000_0001);
        check_eq("rf_r4", rf_model[4], 32'hB000_0004);

        // Mid-stream reset while A streams.
        for (int i = 0; i < 6; i++) a_q.push_back('{addr: 5'(i + 11), data: 32'hC000_0000 + i});
        for (int i = 0; i < 3; i++) step();
        do_reset();
        a_q.push_back('{addr: 5'd20, data: 32'h0BAD_F00D});
        step();
        step();
        check_eq("rf_r20", rf_model[20], 32'h0BAD_F00D);

        // Same-address race after reset: A then B, B's data persists.
        do_reset();
        a_q.push_back('{addr: 5'd7, data: 32'h1});
        b_q.push_back('{addr: 5'd7, data: 32'h2});
        step();
        step();
        step();
        check_eq("rf_r7", rf_model[7], 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_regfile_wb_arbiter
